// File: rtl/hub75_panel_rx.sv
`default_nettype none
// ============================================================================
// Module  : hub75_panel_rx
// Purpose : HUB75 panel receive model that shifts per-half RGB data, commits
//           rows into a 16-row frame buffer on latch and offers registered
//           readback. Optional macro HUB75_RX_SYNC_EN adds a 2-flop input
//           synchronizer ahead of the input stage.
// Revision: 1.0 - initial release
// ============================================================================
module hub75_panel_rx #(
    parameter int COLS     = 32,
    parameter int ROW_BITS = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [2:0]                LED1,
    input  logic [2:0]                LED2,
    input  logic [ROW_BITS-1:0]       rowSelect,
    input  logic                      blank,
    input  logic                      latch,
    input  logic                      sclk,
    input  logic [ROW_BITS:0]         rd_row,
    input  logic [$clog2(COLS)-1:0]   rd_col,
    output logic [2:0]                rd_pixel,
    output logic [ROW_BITS-1:0]       active_row,
    output logic                      disp_on,
    output logic                      frame_done,
    output logic [1:0]                err
);

    localparam int c_NROWS = 2 << ROW_BITS;
    localparam int c_NSEL  = 1 << ROW_BITS;
    localparam int c_CNT_W = $clog2(COLS + 2);
    localparam int c_IN_W  = 3 + 3 + ROW_BITS + 3;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(COLS + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(COLS);
    localparam logic [c_NSEL-1:0]  c_ONE_HOT0 = c_NSEL'(1);

    logic [c_IN_W-1:0]          w_in;
    logic [c_IN_W-1:0]          w_stage_in;
    logic [c_IN_W-1:0]          r_in_q;
    logic                       r_sclk_q_d;
    logic                       r_latch_q_d;
    logic [2:0]                 w_led1_q;
    logic [2:0]                 w_led2_q;
    logic [ROW_BITS-1:0]        w_row_q;
    logic                       w_blank_q;
    logic                       w_latch_q;
    logic                       w_sclk_q;
    logic                       w_shift;
    logic                       w_commit;
    logic [COLS-1:0][2:0]       r_top;
    logic [COLS-1:0][2:0]       r_bot;
    logic [COLS-1:0][2:0]       w_top_nxt;
    logic [COLS-1:0][2:0]       w_bot_nxt;
    logic [c_CNT_W-1:0]         r_cnt;
    logic [c_CNT_W-1:0]         w_cnt_nxt;
    logic [COLS-1:0][2:0]       r_buf [c_NROWS];
    logic [c_NSEL-1:0]          r_row_seen;
    logic [c_NSEL-1:0]          w_sel_mask;
    logic                       w_full;
    logic [2:0]                 r_rd_pixel;
    logic [ROW_BITS-1:0]        r_active_row;
    logic                       r_disp_on;
    logic                       r_frame_done;
    logic [1:0]                 r_err;

    assign w_in = {LED1, LED2, rowSelect, blank, latch, sclk};

`ifdef HUB75_RX_SYNC_EN
    logic [c_IN_W-1:0] r_sync1;
    logic [c_IN_W-1:0] r_sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_stage_in = r_sync2;
`else
    assign w_stage_in = w_in;
`endif

    assign w_led1_q  = r_in_q[c_IN_W-1 -: 3];
    assign w_led2_q  = r_in_q[c_IN_W-4 -: 3];
    assign w_row_q   = r_in_q[ROW_BITS+2:3];
    assign w_blank_q = r_in_q[2];
    assign w_latch_q = r_in_q[1];
    assign w_sclk_q  = r_in_q[0];

    assign w_shift    = w_sclk_q & ~r_sclk_q_d;
    assign w_commit   = w_latch_q & ~r_latch_q_d;
    assign w_sel_mask = c_ONE_HOT0 << w_row_q;
    assign w_full     = (r_row_seen == '1);

    // Shift is resolved before commit so a coincident sclk/latch edge lands
    // its pixel in the committed row and in the count check.
    always_comb begin
        w_top_nxt = r_top;
        w_bot_nxt = r_bot;
        w_cnt_nxt = r_cnt;
        if (w_shift) begin
            w_top_nxt = {r_top[COLS-2:0], w_led1_q};
            w_bot_nxt = {r_bot[COLS-2:0], w_led2_q};
            if (r_cnt != c_CNT_MAX) begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_q       <= '0;
            r_sclk_q_d   <= 1'b0;
            r_latch_q_d  <= 1'b0;
            r_top        <= '0;
            r_bot        <= '0;
            r_cnt        <= '0;
            r_row_seen   <= '0;
            r_active_row <= '0;
            r_disp_on    <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= '0;
        end else begin
            r_in_q       <= w_stage_in;
            r_sclk_q_d   <= w_sclk_q;
            r_latch_q_d  <= w_latch_q;
            r_disp_on    <= ~w_stage_in[2];
            r_top        <= w_top_nxt;
            r_bot        <= w_bot_nxt;
            r_cnt        <= w_commit ? '0 : w_cnt_nxt;
            r_frame_done <= w_full;
            if (w_commit) begin
                r_active_row <= w_row_q;
                if (w_cnt_nxt != c_CNT_FULL) begin
                    r_err[0] <= 1'b1;
                end
                if (!w_blank_q) begin
                    r_err[1] <= 1'b1;
                end
            end
            // A commit in the clearing cycle seeds the next frame's mask.
            if (w_full) begin
                r_row_seen <= w_commit ? w_sel_mask : '0;
            end else if (w_commit) begin
                r_row_seen <= r_row_seen | w_sel_mask;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < c_NROWS; i++) begin
                r_buf[i] <= '0;
            end
            r_rd_pixel <= '0;
        end else begin
            if (w_commit) begin
                r_buf[{1'b0, w_row_q}] <= w_top_nxt;
                r_buf[{1'b1, w_row_q}] <= w_bot_nxt;
            end
            r_rd_pixel <= r_buf[rd_row][rd_col];
        end
    end

    assign rd_pixel   = r_rd_pixel;
    assign active_row = r_active_row;
    assign disp_on    = r_disp_on;
    assign frame_done = r_frame_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hub75_panel_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_hub75_panel_rx
// Purpose : Scoreboard bench for hub75_panel_rx with a behavioural panel model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hub75_panel_rx;

    localparam int COLS     = 32;
    localparam int ROW_BITS = 3;
    localparam int NROWS    = 16;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [2:0]          LED1 = '0;
    logic [2:0]          LED2 = '0;
    logic [ROW_BITS-1:0] rowSelect = '0;
    logic                blank = 1'b1;
    logic                latch = 1'b0;
    logic                sclk = 1'b0;
    logic [ROW_BITS:0]   rd_row = '0;
    logic [4:0]          rd_col = '0;
    logic [2:0]          rd_pixel;
    logic [ROW_BITS-1:0] active_row;
    logic                disp_on;
    logic                frame_done;
    logic [1:0]          err;

    hub75_panel_rx #(.COLS(COLS), .ROW_BITS(ROW_BITS)) dut (
        .clk(clk), .reset_n(reset_n), .LED1(LED1), .LED2(LED2),
        .rowSelect(rowSelect), .blank(blank), .latch(latch), .sclk(sclk),
        .rd_row(rd_row), .rd_col(rd_col), .rd_pixel(rd_pixel),
        .active_row(active_row), .disp_on(disp_on),
        .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural panel model
    logic [2:0]          mtop [COLS];
    logic [2:0]          mbot [COLS];
    logic [2:0]          mbuf [NROWS][COLS];
    int                  mcnt;
    logic [1:0]          merr;
    logic [ROW_BITS-1:0] mact;

    logic [2:0] exp_q [$];
    int checks   = 0;
    int failures = 0;
    int fd_pulses = 0;
    int fd_high   = 0;
    logic fd_prev = 1'b0;

    always @(negedge clk) begin
        if (frame_done) fd_high++;
        if (frame_done && !fd_prev) fd_pulses++;
        fd_prev <= frame_done;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int c = 0; c < COLS; c++) begin
            mtop[c] = '0;
            mbot[c] = '0;
            for (int r = 0; r < NROWS; r++) mbuf[r][c] = '0;
        end
        mcnt = 0;
        merr = '0;
        mact = '0;
    endtask

    task automatic model_shift(input logic [2:0] a, input logic [2:0] b);
        for (int i = COLS - 1; i > 0; i--) begin
            mtop[i] = mtop[i-1];
            mbot[i] = mbot[i-1];
        end
        mtop[0] = a;
        mbot[0] = b;
        if (mcnt < COLS + 1) mcnt++;
    endtask

    task automatic model_commit(input logic [ROW_BITS-1:0] r);
        for (int c = 0; c < COLS; c++) begin
            mbuf[{1'b0, r}][c] = mtop[c];
            mbuf[{1'b1, r}][c] = mbot[c];
        end
        if (mcnt != COLS) merr[0] = 1'b1;
        if (!blank) merr[1] = 1'b1;
        mcnt = 0;
        mact = r;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sclk = 1'b0;
        latch = 1'b0;
        cycles(3);
        model_reset();
        reset_n = 1'b1;
        cycles(2);
    endtask

    task automatic shift_px(input logic [2:0] a, input logic [2:0] b);
        LED1 = a;
        LED2 = b;
        sclk = 1'b1;
        model_shift(a, b);
        cycles(2);
        sclk = 1'b0;
        cycles(2);
    endtask

    task automatic latch_row(input logic [ROW_BITS-1:0] r);
        rowSelect = r;
        latch = 1'b1;
        model_commit(r);
        cycles(2);
        latch = 1'b0;
        cycles(5);
    endtask

    task automatic shift_n(input int n, input logic [2:0] seed);
        for (int k = 0; k < n; k++) begin
            logic [2:0] a;
            a = 3'(k) ^ seed;
            shift_px(a, ~a);
        end
    endtask

    task automatic test_reset();
        blank = 1'b0;
        reset_n = 1'b0;
        model_reset();
        cycles(3);
        checks++;
        if ({err, active_row, disp_on, frame_done, rd_pixel} !== '0) begin
            failures++;
            $display("FAIL reset_outputs err=%b row=%0d disp=%b fd=%b px=%0d exp all 0",
                     err, active_row, disp_on, frame_done, rd_pixel);
        end
        blank = 1'b1;
        reset_n = 1'b1;
        cycles(3);
        for (int i = 0; i <= 2 * COLS; i++) begin
            if (i > 0) begin
                logic [2:0] e;
                e = exp_q.pop_front();
                checks++;
                if (rd_pixel !== e) begin
                    failures++;
                    $display("FAIL reset_buf idx=%0d got=%0d exp=%0d", i - 1, rd_pixel, e);
                end
            end
            if (i < 2 * COLS) begin
                rd_row = (i < COLS) ? 4'd0 : 4'd15;
                rd_col = 5'(i % COLS);
                exp_q.push_back(mbuf[rd_row][rd_col]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_basic_row();
        do_reset();
        blank = 1'b1;
        rowSelect = 3'd3;
        shift_n(COLS, 3'd0);
        latch_row(3'd3);
        checks++;
        if (err !== 2'b00 || active_row !== 3'd3) begin
            failures++;
            $display("FAIL basic_status err=%b row=%0d exp err=00 row=3", err, active_row);
        end
        for (int i = 0; i <= 2 * COLS; i++) begin
            if (i > 0) begin
                logic [2:0] e;
                e = exp_q.pop_front();
                checks++;
                if (rd_pixel !== e) begin
                    failures++;
                    $display("FAIL basic_rd idx=%0d got=%0d exp=%0d", i - 1, rd_pixel, e);
                end
            end
            if (i < 2 * COLS) begin
                rd_row = (i < COLS) ? 4'd3 : 4'd11;
                rd_col = 5'(i % COLS);
                exp_q.push_back(mbuf[rd_row][rd_col]);
            end
            @(negedge clk);
        end
        rd_row = 4'd3;
        rd_col = 5'd31;
        cycles(1);
        checks++;
        if (rd_pixel !== 3'd0) begin
            failures++;
            $display("FAIL basic_corner rd(3,31) got=%0d exp=0", rd_pixel);
        end
        rd_col = 5'd0;
        cycles(1);
        checks++;
        if (rd_pixel !== 3'd7) begin
            failures++;
            $display("FAIL basic_corner rd(3,0) got=%0d exp=7", rd_pixel);
        end
    endtask

    task automatic test_frame_done();
        int p0, h0;
        do_reset();
        p0 = fd_pulses;
        h0 = fd_high;
        for (int r = 0; r < 8; r++) begin
            shift_n(COLS, 3'(r));
            latch_row(3'(r));
        end
        checks++;
        if (fd_pulses - p0 !== 1 || fd_high - h0 !== 1) begin
            failures++;
            $display("FAIL frame_done_full pulses=%0d high_cycles=%0d exp 1/1",
                     fd_pulses - p0, fd_high - h0);
        end
        for (int r = 0; r < 7; r++) begin
            shift_n(COLS, 3'(r + 2));
            latch_row(3'(r));
        end
        checks++;
        if (fd_pulses - p0 !== 1) begin
            failures++;
            $display("FAIL frame_done_partial pulses=%0d exp 1", fd_pulses - p0);
        end
        checks++;
        if (err !== merr || active_row !== mact) begin
            failures++;
            $display("FAIL frame_status err=%b row=%0d exp err=%b row=%0d",
                     err, active_row, merr, mact);
        end
        for (int i = 0; i <= NROWS * COLS; i++) begin
            if (i > 0) begin
                logic [2:0] e;
                e = exp_q.pop_front();
                checks++;
                if (rd_pixel !== e) begin
                    failures++;
                    $display("FAIL frame_rd idx=%0d got=%0d exp=%0d", i - 1, rd_pixel, e);
                end
            end
            if (i < NROWS * COLS) begin
                rd_row = 4'(i / COLS);
                rd_col = 5'(i % COLS);
                exp_q.push_back(mbuf[rd_row][rd_col]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_count_err();
        do_reset();
        shift_n(COLS - 1, 3'd1);
        latch_row(3'd1);
        checks++;
        if (err !== 2'b01) begin
            failures++;
            $display("FAIL short_row err=%b exp=01", err);
        end
        shift_n(COLS + 1, 3'd2);
        latch_row(3'd2);
        checks++;
        if (err !== 2'b01 || active_row !== 3'd2) begin
            failures++;
            $display("FAIL long_row err=%b row=%0d exp err=01 row=2", err, active_row);
        end
        do_reset();
        checks++;
        if (err !== 2'b00) begin
            failures++;
            $display("FAIL err_clear err=%b exp=00", err);
        end
    endtask

    task automatic test_blank_latch();
        do_reset();
        blank = 1'b0;
        cycles(3);
        checks++;
        if (disp_on !== 1'b1) begin
            failures++;
            $display("FAIL disp_on got=%b exp=1", disp_on);
        end
        shift_n(COLS, 3'd4);
        latch_row(3'd4);
        checks++;
        if (err !== 2'b10 || active_row !== 3'd4) begin
            failures++;
            $display("FAIL blank_latch err=%b row=%0d exp err=10 row=4", err, active_row);
        end
        for (int i = 0; i <= 2 * COLS; i++) begin
            if (i > 0) begin
                logic [2:0] e;
                e = exp_q.pop_front();
                checks++;
                if (rd_pixel !== e) begin
                    failures++;
                    $display("FAIL blank_rd idx=%0d got=%0d exp=%0d", i - 1, rd_pixel, e);
                end
            end
            if (i < 2 * COLS) begin
                rd_row = (i < COLS) ? 4'd4 : 4'd12;
                rd_col = 5'(i % COLS);
                exp_q.push_back(mbuf[rd_row][rd_col]);
            end
            @(negedge clk);
        end
        blank = 1'b1;
        cycles(3);
        checks++;
        if (disp_on !== 1'b0) begin
            failures++;
            $display("FAIL disp_off got=%b exp=0", disp_on);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        shift_n(COLS - 1, 3'd5);
        LED1 = 3'd6;
        LED2 = 3'd1;
        rowSelect = 3'd6;
        sclk = 1'b1;
        latch = 1'b1;
        model_shift(3'd6, 3'd1);
        model_commit(3'd6);
        cycles(2);
        sclk = 1'b0;
        latch = 1'b0;
        cycles(5);
        checks++;
        if (err !== 2'b00 || active_row !== 3'd6) begin
            failures++;
            $display("FAIL simul_status err=%b row=%0d exp err=00 row=6", err, active_row);
        end
        rd_row = 4'd6;
        rd_col = 5'd0;
        cycles(1);
        checks++;
        if (rd_pixel !== 3'd6) begin
            failures++;
            $display("FAIL simul_col0 got=%0d exp=6", rd_pixel);
        end
        for (int i = 0; i <= 2 * COLS; i++) begin
            if (i > 0) begin
                logic [2:0] e;
                e = exp_q.pop_front();
                checks++;
                if (rd_pixel !== e) begin
                    failures++;
                    $display("FAIL simul_rd idx=%0d got=%0d exp=%0d", i - 1, rd_pixel, e);
                end
            end
            if (i < 2 * COLS) begin
                rd_row = (i < COLS) ? 4'd6 : 4'd14;
                rd_col = 5'(i % COLS);
                exp_q.push_back(mbuf[rd_row][rd_col]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_row();
        do_reset();
        shift_n(10, 3'd3);
        do_reset();
        shift_n(COLS, 3'd6);
        latch_row(3'd5);
        checks++;
        if (err !== 2'b00 || active_row !== 3'd5) begin
            failures++;
            $display("FAIL midreset_status err=%b row=%0d exp err=00 row=5", err, active_row);
        end
        for (int i = 0; i <= NROWS * COLS; i++) begin
            if (i > 0) begin
                logic [2:0] e;
                e = exp_q.pop_front();
                checks++;
                if (rd_pixel !== e) begin
                    failures++;
                    $display("FAIL midreset_rd idx=%0d got=%0d exp=%0d", i - 1, rd_pixel, e);
                end
            end
            if (i < NROWS * COLS) begin
                rd_row = 4'(i / COLS);
                rd_col = 5'(i % COLS);
                exp_q.push_back(mbuf[rd_row][rd_col]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic_row();
        test_frame_done();
        test_count_err();
        test_blank_latch();
        test_simultaneous();
        test_reset_mid_row();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hub75_panel_rx.md
# hub75_panel_rx

Receive-side model of the RGB matrix panel interface driven by the LED top-level. It samples `LED1`, `LED2`, `rowSelect`, `blank`, `latch` and `sclk` in the system clock domain and shifts colour data per half-panel. On each latch it commits the shifted row into a 16-row frame buffer. The buffer is readable through a registered port, so benches and on-chip self-check logic can compare displayed content against the generator.

## Interface
- `COLS`, 32: pixels shifted per row per half; must be ≥2.
- `ROW_BITS`, 3: width of `rowSelect`; the panel has 2·2^ROW_BITS rows.
- `clk` input 1: single system clock, all logic on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `LED1` input 3: top-half RGB bit per `sclk` pulse.
- `LED2` input 3: bottom-half RGB bit per `sclk` pulse.
- `rowSelect` input ROW_BITS: row address, sampled at latch.
- `blank` input 1: 1 = display off.
- `latch` input 1: rising edge commits shift registers.
- `sclk` input 1: rising edge shifts one pixel.
- `rd_row` input ROW_BITS+1: readback row; MSB=1 selects bottom half.
- `rd_col` input $clog2(COLS): readback column.
- `rd_pixel` output 3: RGB at (`rd_row`,`rd_col`), 1-cycle latency.
- `active_row` output ROW_BITS: row address of last commit.
- `disp_on` output 1: registered `~blank`.
- `frame_done` output 1: 1-cycle pulse when every row address has been committed since the last pulse.
- `err` output 2: sticky; [0] = commit with shift count ≠ COLS, [1] = latch rise while `blank`=0.

## Operation
- Input stage: all six panel inputs registered once (`*_q`); `sclk_q_d`/`latch_q_d` delayed copies for edge detect.
- Shift: when `sclk_q & ~sclk_q_d` occurs, top shift reg ← {top[COLS-2:0], LED1_q}, bottom likewise with LED2_q. The k-th pixel shifted after a latch (k=0..COLS-1) lands at column COLS-1-k.
- `shift_cnt`: increments per shift, saturates at COLS+1, clears on commit.
- Commit: on `latch_q & ~latch_q_d`:
  - Write top shift reg to buffer row {0,rowSelect_q} and bottom shift reg to {1,rowSelect_q}, whole row in one cycle.
  - `active_row` ← rowSelect_q; set bit rowSelect_q of `row_seen`.
  - Set err[0] if post-shift count ≠ COLS; set err[1] if `blank_q`=0.
- Simultaneous shift and commit in one cycle: the shift is applied first; the committed row includes the new pixel and it counts toward `shift_cnt`.
- Shift registers are not cleared by a commit; their contents persist until shifted out.
- `frame_done`: asserted the cycle after `row_seen` becomes all-ones; `row_seen` clears in that same cycle. A commit in the clearing cycle sets its bit in the fresh mask. Repeated rows within a frame are ignored.
- Readback: `rd_pixel` ← buffer[rd_row][rd_col] registered. A write and a read to the same location in the same cycle return the old data.
- Reset (any time, including mid-row): all shift regs, buffer, counters, `row_seen`, `err`, `active_row`, `disp_on`, `frame_done` and `rd_pixel` go to 0. The partial row is discarded.

## Timing
- Input edge at cycle n is registered at edge n+1; shift/commit takes effect at edge n+2.
- Committed data is visible on `rd_pixel` one cycle after the commit edge plus the read latency (1).
- `disp_on` lags `blank` by 1 cycle; `frame_done` is a single-cycle pulse, 1 cycle after the completing commit.
- `sclk` high and low phases must each be ≥2 `clk` cycles for reliable edge detection; shorter pulses may be missed and are then reported via err[0].

## Configuration
- `HUB75_RX_SYNC_EN` defined: adds a 2-flop synchronizer ahead of the input stage on all panel inputs, for driving from an asynchronous or off-chip source. Input-to-effect latency becomes 4 cycles and minimum phase width stays at 2 cycles.
- Not defined: single register stage only; inputs must be synchronous to `clk`.

## Test plan
- Reset, shift 32 pixels LED1=k[2:0], LED2=~k[2:0] (k=0..31), blank=1, latch, rowSelect=3 -> rd(3,31)=0, rd(3,0)=7, rd(11,31)=7, err=0, active_row=3.
- Commit rows 0..7 in order -> one `frame_done` pulse after row 7; repeat rows 0..6 only -> no pulse.
- Shift 31 then latch -> err[0]=1; 33 then latch -> err[0] stays 1 until reset_n=0, then err=0.
- Latch rise with blank=0 -> err[1]=1, row still committed.
- sclk rise and latch rise in same cycle after 31 prior shifts -> err[0]=0, 32nd pixel at column 0.
- Assert reset_n mid-row after 10 shifts, then full row to rowSelect=5 -> rd(5,*) matches only post-reset data, all other rows 0.
